// File: rtl/multicycle_controlunit.sv
// Multicycle MIPS control unit.
// Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
// Memory requests are held until ihit/dhit arrives or the wait budget expires.
// Optional build macro RETIRE_COUNT_EN adds the 32-bit instret output.
//
// ALUop encoding (aluop_t):
//   SLL=0 SRL=1 ADD=2 SUB=3 AND=4 OR=5 XOR=6 NOR=7 ADDU=8 SUBU=9 SLT=10 SLTU=11
//
// state  | meaning
// IDLE   | post-reset, one cycle before the first fetch
// FETCH  | instruction read outstanding, IR loads on ihit
// DECODE | IR decoded; jumps, JAL link and halts resolved here
// EXEC   | ALU operating; branches resolve and retire here
// MEM    | data read/write outstanding until dhit
// WB     | register write-back and PC advance
// HALTED | sticky stop, only nRST leaves

module multicycle_controlunit #(
    parameter int WORD_W          = 32,
    parameter int MEM_TIMEOUT     = 255,
    parameter int TMO_W           = 8,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] imemload,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              zero,
    output logic              imemREN,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] instr,
    output logic              pc_en,
    output logic [1:0]        pc_src,
    output logic [3:0]        ALUop,
    output logic              ALUsrc,
    output logic [1:0]        ext,
    output logic [1:0]        RegDst,
    output logic              WEN,
    output logic [1:0]        RFWdata,
    output logic              halt,
    output logic              timeout_err
`ifdef RETIRE_COUNT_EN
    ,
    output logic [31:0]       instret
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALTED
    } state_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_ADDU = 4'd8,
        ALU_SUBU = 4'd9,
        ALU_SLT  = 4'd10,
        ALU_SLTU = 4'd11
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Last wait count at which a missing hit still gets one more chance;
    // a miss here means MEM_TIMEOUT cycles have elapsed without a hit.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           state, next_state;
    logic [TMO_W-1:0] wait_cnt;
    logic             tmo_flag;
    logic             tmo_fire;

    logic [5:0] opcode;
    logic [5:0] funct;
    aluop_t     dec_aluop;
    logic       dec_alusrc;
    logic [1:0] dec_ext;
    logic       is_rtype, is_jr, is_j, is_jal, is_beq, is_bne;
    logic       is_lw, is_sw, is_lui, is_halt, is_illegal;
    logic       branch_taken;

    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];
    assign timeout_err = tmo_flag;

    // Instruction class and ALU control decoded from the latched IR.
    always_comb begin
        dec_aluop  = ALU_ADD;
        dec_alusrc = 1'b0;
        dec_ext    = 2'd0;
        is_rtype   = 1'b0;
        is_jr      = 1'b0;
        is_j       = 1'b0;
        is_jal     = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_lui     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                is_rtype = 1'b1;
                case (funct)
                    FN_SLL:  dec_aluop = ALU_SLL;
                    FN_SRL:  dec_aluop = ALU_SRL;
                    FN_JR:   is_jr     = 1'b1;
                    FN_ADD:  dec_aluop = ALU_ADD;
                    FN_ADDU: dec_aluop = ALU_ADDU;
                    FN_SUB:  dec_aluop = ALU_SUB;
                    FN_SUBU: dec_aluop = ALU_SUBU;
                    FN_AND:  dec_aluop = ALU_AND;
                    FN_OR:   dec_aluop = ALU_OR;
                    FN_XOR:  dec_aluop = ALU_XOR;
                    FN_NOR:  dec_aluop = ALU_NOR;
                    FN_SLT:  dec_aluop = ALU_SLT;
                    FN_SLTU: dec_aluop = ALU_SLTU;
                    default: is_illegal = 1'b1;
                endcase
            end
            OP_J:   is_j   = 1'b1;
            OP_JAL: is_jal = 1'b1;
            // Branch offset is a signed word displacement, hence sign-extend.
            OP_BEQ: begin
                is_beq    = 1'b1;
                dec_aluop = ALU_SUB;
                dec_ext   = 2'd1;
            end
            OP_BNE: begin
                is_bne    = 1'b1;
                dec_aluop = ALU_SUB;
                dec_ext   = 2'd1;
            end
            OP_ADDI: begin
                dec_aluop  = ALU_ADD;
                dec_alusrc = 1'b1;
                dec_ext    = 2'd1;
            end
            OP_ADDIU: begin
                dec_aluop  = ALU_ADDU;
                dec_alusrc = 1'b1;
                dec_ext    = 2'd1;
            end
            OP_SLTI: begin
                dec_aluop  = ALU_SLT;
                dec_alusrc = 1'b1;
                dec_ext    = 2'd1;
            end
            OP_SLTIU: begin
                dec_aluop  = ALU_SLTU;
                dec_alusrc = 1'b1;
                dec_ext    = 2'd1;
            end
            OP_ANDI: begin
                dec_aluop  = ALU_AND;
                dec_alusrc = 1'b1;
            end
            OP_ORI: begin
                dec_aluop  = ALU_OR;
                dec_alusrc = 1'b1;
            end
            OP_XORI: begin
                dec_aluop  = ALU_XOR;
                dec_alusrc = 1'b1;
            end
            // The upper-immediate value is written straight from the extender.
            OP_LUI: begin
                is_lui     = 1'b1;
                dec_alusrc = 1'b1;
                dec_ext    = 2'd2;
            end
            OP_LW: begin
                is_lw      = 1'b1;
                dec_alusrc = 1'b1;
                dec_ext    = 2'd1;
            end
            OP_SW: begin
                is_sw      = 1'b1;
                dec_alusrc = 1'b1;
                dec_ext    = 2'd1;
            end
            OP_HALT: is_halt    = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

    assign branch_taken = (is_beq && zero) || (is_bne && !zero);

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-phase datapath controls.
    always_comb begin
        next_state = state;
        imemREN    = 1'b0;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'd0;
        ALUop      = 4'd0;
        ALUsrc     = 1'b0;
        ext        = 2'd0;
        RegDst     = 2'd0;
        WEN        = 1'b0;
        RFWdata    = 2'd0;
        halt       = 1'b0;
        tmo_fire   = 1'b0;

        if (state inside {EXEC, MEM, WB}) begin
            ALUop  = dec_aluop;
            ALUsrc = dec_alusrc;
            ext    = dec_ext;
        end

        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    next_state = DECODE;
                end else if (wait_cnt == TMO_LAST) begin
                    tmo_fire   = 1'b1;
                    next_state = HALTED;
                end
            end
            DECODE: begin
                if (is_halt) begin
                    next_state = HALTED;
                end else if (is_j || is_jal) begin
                    pc_en      = 1'b1;
                    pc_src     = 2'd2;
                    next_state = FETCH;
                    if (is_jal) begin
                        WEN     = 1'b1;
                        RegDst  = 2'd2;
                        RFWdata = 2'd2;
                    end
                end else if (is_jr) begin
                    pc_en      = 1'b1;
                    pc_src     = 2'd3;
                    next_state = FETCH;
                end else if (is_illegal) begin
                    if (HALT_ON_ILLEGAL) begin
                        next_state = HALTED;
                    end else begin
                        pc_en      = 1'b1;
                        next_state = FETCH;
                    end
                end else begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (is_beq || is_bne) begin
                    pc_en      = 1'b1;
                    pc_src     = branch_taken ? 2'd1 : 2'd0;
                    next_state = FETCH;
                end else if (is_lw || is_sw) begin
                    next_state = MEM;
                end else begin
                    next_state = WB;
                end
            end
            MEM: begin
                dmemREN = is_lw;
                dmemWEN = is_sw;
                if (dhit) begin
                    if (is_lw) begin
                        next_state = WB;
                    end else begin
                        pc_en      = 1'b1;
                        next_state = FETCH;
                    end
                end else if (wait_cnt == TMO_LAST) begin
                    tmo_fire   = 1'b1;
                    next_state = HALTED;
                end
            end
            WB: begin
                WEN        = 1'b1;
                pc_en      = 1'b1;
                RegDst     = is_rtype ? 2'd1 : 2'd0;
                RFWdata    = is_lw ? 2'd1 : (is_lui ? 2'd3 : 2'd0);
                next_state = FETCH;
            end
            HALTED: halt = 1'b1;
            default: next_state = IDLE;
        endcase
    end

    // Instruction register, loaded only on a completed fetch.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr <= '0;
        end else if (state == FETCH && ihit) begin
            instr <= imemload;
        end
    end

    // Memory wait counter: restarts on entry to FETCH/MEM, counts missed cycles.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_cnt <= '0;
        end else if (next_state != state && (next_state == FETCH || next_state == MEM)) begin
            wait_cnt <= '0;
        end else if ((state == FETCH && !ihit) || (state == MEM && !dhit)) begin
            wait_cnt <= wait_cnt + TMO_W'(1);
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tmo_flag <= 1'b0;
        end else if (tmo_fire) begin
            tmo_flag <= 1'b1;
        end
    end

`ifdef RETIRE_COUNT_EN
    // Retired-instruction counter; pc_en is never raised in HALTED so it freezes there.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instret <= 32'd0;
        end else if (pc_en && state != HALTED) begin
            instret <= instret + 32'd1;
        end
    end
`endif

endmodule
